// File: rtl/mem_req_arb.sv
// Round-robin arbiter that funnels per-requester cache-line reads into one memory port,
// tracking outstanding transactions by slot so responses route back to their owner in any order.
module mem_req_arb #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int MAX_OUT = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_val,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]    req_addr,
    output logic [NUM_REQ-1:0]                req_rdy,
    output logic                              mem_req_val,
    input  logic                              mem_req_rdy,
    output logic [ADDR_W-1:0]                 mem_req_addr,
    output logic [5:0]                        mem_req_transid,
    input  logic                              mem_resp_val,
    input  logic [5:0]                        mem_resp_transid,
    input  logic [511:0]                      mem_resp_data,
    output logic [NUM_REQ-1:0]                resp_val,
    output logic [511:0]                      resp_data,
    output logic [$clog2(MAX_OUT):0]          outstanding,
    output logic                              err_unexp
);

    localparam int SLOT_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int OWN_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W  = $clog2(MAX_OUT) + 1;

    logic [MAX_OUT-1:0] slot_busy;
    logic [OWN_W-1:0]   slot_owner [MAX_OUT];
    logic [OWN_W-1:0]   rr_ptr;
    logic [OWN_W-1:0]   rr_next;

    logic               grant_found;
    logic [OWN_W-1:0]   grant_idx;
    logic               slot_avail;
    logic [SLOT_W-1:0]  free_idx;
    logic               can_accept;
    logic               accept;
    logic               drain;
    logic               resp_in_range;
    logic               resp_hit;
    logic [SLOT_W-1:0]  resp_slot;

    // Round-robin search starting at rr_ptr, wrapping past NUM_REQ-1.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_found && req_val[idx]) begin
                grant_found = 1'b1;
                grant_idx   = OWN_W'(idx);
            end
        end
    end

    // Lowest-index free slot; only slots already free at cycle start count.
    always_comb begin
        slot_avail = ~&slot_busy;
        free_idx   = '0;
        for (int i = MAX_OUT - 1; i >= 0; i--) begin
            if (!slot_busy[i]) free_idx = SLOT_W'(i);
        end
    end

    assign drain      = mem_req_val & mem_req_rdy;
    assign can_accept = rst_n & (~mem_req_val | mem_req_rdy) & slot_avail;
    assign accept     = can_accept & grant_found;
    assign rr_next    = (grant_idx == OWN_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        req_rdy = '0;
        if (accept) req_rdy[grant_idx] = 1'b1;
    end

    // Out-of-range transids never index the slot table as a hit.
    assign resp_in_range = {1'b0, mem_resp_transid} < 7'(MAX_OUT);
    assign resp_slot     = mem_resp_transid[SLOT_W-1:0];
    assign resp_hit      = mem_resp_val & resp_in_range & slot_busy[resp_slot];

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_busy       <= '0;
            rr_ptr          <= '0;
            mem_req_val     <= 1'b0;
            mem_req_addr    <= '0;
            mem_req_transid <= '0;
            resp_val        <= '0;
            resp_data       <= '0;
            outstanding     <= '0;
            err_unexp       <= 1'b0;
        end else begin
            if (accept) begin
                slot_busy[free_idx] <= 1'b1;
                rr_ptr              <= rr_next;
                mem_req_val         <= 1'b1;
                mem_req_addr        <= req_addr[grant_idx];
                mem_req_transid     <= 6'(free_idx);
            end else if (drain) begin
                mem_req_val <= 1'b0;
            end

            resp_val <= '0;
            if (resp_hit) begin
                slot_busy[resp_slot]             <= 1'b0;
                resp_val[slot_owner[resp_slot]]  <= 1'b1;
                resp_data                        <= mem_resp_data;
            end else if (mem_resp_val) begin
                err_unexp <= 1'b1;
            end

            // Allocation and free always target different slots, so they net out.
            case ({accept, resp_hit})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // NOTE: the owner table is deliberately not reset; slot_busy qualifies every read, so stale owners are never used.
    always_ff @(posedge clk) begin
        if (accept) slot_owner[free_idx] <= grant_idx;
    end

endmodule

// File: doc/mem_req_arb.md
MEM_REQ_ARB -- requirements
Module: mem_req_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (vector prefetcher, matrix streamers).
REQ-002 SHALL have parameter ADDR_W, default 32, request address width.
REQ-003 SHALL have parameter MAX_OUT, default 8, outstanding-transaction slots (power of 2, at most 64).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 req_val  in  NUM_REQ  per-requester request valid.
REQ-007 req_addr  in  NUM_REQ x ADDR_W  per-requester cache-line address.
REQ-008 req_rdy  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-009 mem_req_val  out  1  request to memory valid.
REQ-010 mem_req_rdy  in  1  memory accepts request.
REQ-011 mem_req_addr  out  ADDR_W  address to memory.
REQ-012 mem_req_transid  out  6  slot index, zero-extended.
REQ-013 mem_resp_val  in  1  memory response valid.
REQ-014 mem_resp_transid  in  6  transid of response.
REQ-015 mem_resp_data  in  512  response cache line.
REQ-016 resp_val  out  NUM_REQ  one-cycle response strobe to the owning requester.
REQ-017 resp_data  out  512  shared response data, valid with any resp_val bit.
REQ-018 outstanding  out  clog2(MAX_OUT)+1  count of allocated slots.
REQ-019 err_unexp  out  1  sticky flag: response for an unallocated slot or out-of-range transid.

Function
REQ-020 SHALL hold one output request register; mem_req_val high while it is full; contents stable until mem_req_val & mem_req_rdy.
REQ-021 can_accept SHALL be (register empty, or mem_req_val & mem_req_rdy this cycle) and at least one slot free at cycle start.
REQ-022 grant SHALL be round-robin among req_val bits, searching from rr_ptr upward with wrap; req_rdy[g]=can_accept for the granted g only; req_rdy combinational from req_val and state.
REQ-023 On req_val[g] & req_rdy[g]: lowest-index free slot s allocated with owner=g; register loaded with req_addr[g] and transid=s; rr_ptr <= (g+1) mod NUM_REQ.
REQ-024 rr_ptr SHALL NOT change in cycles without an accepted handshake.
REQ-025 On mem_resp_val with allocated transid t: next cycle resp_val[owner(t)]=1 for exactly one cycle, resp_data=mem_resp_data; slot t freed at that edge.
REQ-026 A slot freed at edge N SHALL NOT be counted free before the cycle following edge N (no same-cycle reuse).
REQ-027 Response to an unallocated or >=MAX_OUT transid: no resp_val, no state change except err_unexp<=1.
REQ-028 Simultaneous allocate and free in one cycle: outstanding unchanged; both slot updates take effect.
REQ-029 outstanding=MAX_OUT: all req_rdy low; register may still drain to memory.
REQ-030 Responses may return in any order; routing depends only on transid.

Reset
REQ-031 While rst_n=0 at a rising edge: all slots free, rr_ptr=0, register empty, mem_req_val=0, resp_val=0, resp_data=0, outstanding=0, err_unexp=0; mem_req_addr and mem_req_transid=0.
REQ-032 Reset mid-transaction SHALL drop all outstanding slots; later responses to them set err_unexp.

Verification
REQ-033 Single request: req_val[1]=1, addr 0x240, mem_req_rdy=1 -> req_rdy[1] same cycle, mem_req_val next cycle with addr 0x240, transid 0; response transid 0 -> resp_val[1] one cycle later, outstanding back to 0.
REQ-034 Fairness: all four req_val held high, mem_req_rdy=1, responses immediate -> grant order 0,1,2,3,0,1...
REQ-035 Full: MAX_OUT=8, no responses -> eight accepts (transids 0..7), req_rdy stays low, outstanding=8; one response transid 3 -> next accept uses transid 3 no earlier than the cycle after the free.
REQ-036 Backpressure: mem_req_rdy=0 for 5 cycles -> mem_req_val, addr, transid stable; exactly one request accepted from requesters.
REQ-037 Out-of-order return: transids 0,1,2 to requesters 0,1,2 answered 2,0,1 -> resp_val bits 2,0,1 with matching data; stray transid 9 -> err_unexp=1, no resp_val.
REQ-038 Reset with 3 outstanding -> outstanding=0, mem_req_val=0 after one edge; stale response sets err_unexp.
